// File: rtl/replacement_sched.sv
// Victim-way scheduler shared by several cache requesters.
// A round-robin arbiter grants one requester at a time. The granted set masks
// are captured, and one cycle later a victim way is picked. The preference order
// is: an invalid unlocked way first, then the random way, then the next unlocked
// way after it. The result is held until the consumer accepts it.
module replacement_sched #(
    parameter int NUM_REQ  = 2,
    parameter int WAYS     = 4,
    parameter int WAY_BITS = $clog2(WAYS),
    localparam int ID_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WAY_BITS-1:0]       rnd,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*WAYS-1:0]   req_vmask,
    input  logic [NUM_REQ*WAYS-1:0]   req_lmask,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_BITS-1:0]        rsp_id,
    output logic [WAY_BITS-1:0]       rsp_way,
    output logic                      rsp_none
);

    typedef enum logic [1:0] {IDLE, PICK, RESP} state_t;

    state_t               state;
    logic [ID_BITS-1:0]   rr;
    logic [ID_BITS-1:0]   cap_id;
    logic [WAYS-1:0]      cap_vmask;
    logic [WAYS-1:0]      cap_lmask;

    logic                 grant_found;
    logic [ID_BITS-1:0]   grant_id;
    logic [ID_BITS-1:0]   next_rr;
    logic [NUM_REQ-1:0]   grant_vec;
    logic [WAYS-1:0]      grant_vmask;
    logic [WAYS-1:0]      grant_lmask;

    logic [WAYS-1:0]      eligible;
    logic [WAYS-1:0]      invalid_eligible;
    logic [WAY_BITS-1:0]  pick_way;
    logic                 pick_none;

    // Round-robin search from rr upward, wrapping; the first valid requester wins and its masks are selected
    always_comb begin : grant_search
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        next_rr     = '0;
        grant_vec   = '0;
        grant_vmask = '0;
        grant_lmask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr) + i) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found    = 1'b1;
                grant_id       = ID_BITS'(idx);
                next_rr        = ID_BITS'((idx + 1) % NUM_REQ);
                grant_vec[idx] = 1'b1;
                grant_vmask    = req_vmask[idx*WAYS +: WAYS];
                grant_lmask    = req_lmask[idx*WAYS +: WAYS];
            end
        end
    end

    assign req_ready = (state == IDLE && !reset) ? grant_vec : '0;

    // Victim choice from the captured masks: invalid unlocked way, else rnd, else next unlocked way after rnd
    always_comb begin : victim_select
        int   idx;
        logic found;
        idx              = 0;
        found            = 1'b0;
        pick_way         = '0;
        eligible         = ~cap_lmask;
        invalid_eligible = eligible & ~cap_vmask;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && invalid_eligible[i]) begin
                found    = 1'b1;
                pick_way = WAY_BITS'(i);
            end
        end
        if (!found && eligible[rnd]) begin
            found    = 1'b1;
            pick_way = rnd;
        end
        for (int i = 1; i < WAYS; i++) begin
            idx = (int'(rnd) + i) % WAYS;
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                pick_way = WAY_BITS'(idx);
            end
        end
        pick_none = !found;
    end

    // Controller: capture on grant, register the victim in PICK, hold the response until it is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= '0;
            cap_id    <= '0;
            cap_vmask <= '0;
            cap_lmask <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_way   <= '0;
            rsp_none  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        cap_id    <= grant_id;
                        cap_vmask <= grant_vmask;
                        cap_lmask <= grant_lmask;
                        rr        <= next_rr;
                        state     <= PICK;
                    end
                end
                PICK: begin
                    rsp_id    <= cap_id;
                    rsp_way   <= pick_way;
                    rsp_none  <= pick_none;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_replacement_sched.sv
// Directed self-checking bench for replacement_sched (NUM_REQ=2, WAYS=4).
module tb_replacement_sched;

    localparam int NUM_REQ  = 2;
    localparam int WAYS     = 4;
    localparam int WAY_BITS = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [WAY_BITS-1:0]     rnd;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*WAYS-1:0] req_vmask;
    logic [NUM_REQ*WAYS-1:0] req_lmask;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_id;
    logic [WAY_BITS-1:0]     rsp_way;
    logic                    rsp_none;

    int checks   = 0;
    int failures = 0;

    replacement_sched #(.NUM_REQ(NUM_REQ), .WAYS(WAYS)) dut (
        .clk       (clk),
        .reset     (reset),
        .rnd       (rnd),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_vmask (req_vmask),
        .req_lmask (req_lmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_way   (rsp_way),
        .rsp_none  (rsp_none)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] vmask,
                                 input logic [7:0] lmask, input logic [1:0] rnd_v,
                                 input logic rready);
        req_valid = valid;
        req_vmask = vmask;
        req_lmask = lmask;
        rnd       = rnd_v;
        rsp_ready = rready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full transaction from a single requester; rnd differs outside the PICK cycle
    task automatic doPick(input string tag, input int id, input logic [3:0] vm,
                          input logic [3:0] lm, input logic [1:0] r,
                          input logic [1:0] exp_way, input logic exp_none);
        logic [7:0] vmf;
        logic [7:0] lmf;
        logic [1:0] vf;
        vmf = '0;
        lmf = '0;
        vf  = '0;
        vmf[id*4 +: 4] = vm;
        lmf[id*4 +: 4] = lm;
        vf[id]         = 1'b1;
        applyStimulus(vf, vmf, lmf, ~r, 1'b0);
        #1;
        checkOutput({tag, " grant req_ready"}, 32'(req_ready), 32'(vf));
        checkOutput({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        applyStimulus(2'b00, 8'h00, 8'hFF, r, 1'b0);
        #1;
        checkOutput({tag, " pick req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, " pick rsp_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        applyStimulus(2'b00, 8'h00, 8'hFF, ~r, 1'b1);
        #1;
        checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
        checkOutput({tag, " rsp_way"}, 32'(rsp_way), 32'(exp_way));
        checkOutput({tag, " rsp_none"}, 32'(rsp_none), 32'(exp_none));
        checkOutput({tag, " resp req_ready"}, 32'(req_ready), 32'd0);
        tick();
        applyStimulus(2'b00, 8'h00, 8'h00, 2'd0, 1'b0);
        #1;
        checkOutput({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        // Reset with both requesters asking: nothing may be granted
        reset = 1'b1;
        applyStimulus(2'b11, 8'hFF, 8'h00, 2'd0, 1'b0);
        tick();
        tick();
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset rsp_way", 32'(rsp_way), 32'd0);
        checkOutput("reset rsp_none", 32'(rsp_none), 32'd0);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'd0, 1'b0);
        reset = 1'b0;
        tick();

        // Victim selection cases
        doPick("invalid_first", 0, 4'b1011, 4'b0000, 2'd0, 2'd2, 1'b0);
        doPick("rnd_way",       0, 4'b1111, 4'b0000, 2'd3, 2'd3, 1'b0);
        doPick("rnd_wrap",      0, 4'b1111, 4'b1000, 2'd3, 2'd0, 1'b0);
        doPick("skip_locked",   0, 4'b0000, 4'b0001, 2'd0, 2'd1, 1'b0);
        doPick("all_locked",    0, 4'b0101, 4'b1111, 2'd2, 2'd0, 1'b1);
        doPick("req1_scan",     1, 4'b1111, 4'b0110, 2'd1, 2'd3, 1'b0);
        doPick("req1_rnd2",     1, 4'b1111, 4'b0000, 2'd2, 2'd2, 1'b0);

        // Reset pulse so round-robin starts from requester 0
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Both requesters held valid: grants alternate 0,1,0,1 with a result every third cycle
        applyStimulus(2'b11, {4'b1110, 4'b0111}, 8'h00, 2'd0, 1'b1);
        for (int g = 0; g < 4; g++) begin
            #1;
            checkOutput("rr grant", 32'(req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput("rr idle rsp_valid", 32'(rsp_valid), 32'd0);
            tick();
            #1;
            checkOutput("rr pick req_ready", 32'(req_ready), 32'd0);
            tick();
            #1;
            checkOutput("rr rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rr rsp_id", 32'(rsp_id), 32'(g % 2));
            checkOutput("rr rsp_way", 32'(rsp_way), (g % 2 == 0) ? 32'd3 : 32'd0);
            checkOutput("rr resp req_ready", 32'(req_ready), 32'd0);
            tick();
        end

        // Back in IDLE with rr=0: grant requester 0, then stall the response
        applyStimulus(2'b11, {4'b1110, 4'b0111}, 8'h00, 2'd0, 1'b0);
        #1;
        checkOutput("stall grant", 32'(req_ready), 32'd1);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            rnd = 2'(c);
            #1;
            checkOutput("stall rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall rsp_id", 32'(rsp_id), 32'd0);
            checkOutput("stall rsp_way", 32'(rsp_way), 32'd3);
            checkOutput("stall rsp_none", 32'(rsp_none), 32'd0);
            checkOutput("stall req_ready", 32'(req_ready), 32'd0);
            tick();
        end

        // Reset in RESP (rr is 1 here) aborts the result; next grant goes to requester 0
        reset = 1'b1;
        #1;
        checkOutput("abort rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort req_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("post reset grant", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(2'b00, 8'h00, 8'h00, 2'd0, 1'b1);
        tick();
        #1;
        checkOutput("post reset rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("post reset rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("post reset rsp_way", 32'(rsp_way), 32'd3);
        tick();
        #1;
        checkOutput("post reset rsp drop", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
